// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: default widths and the octant code layout
// used by the pre stage, the iteration core and the post stage.
package cordic_pkg;

    // Default input width and left-shift headroom for the core
    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_GUARD = 2;

    // Octant code bit positions
    localparam int unsigned Q_W    = 3;
    localparam int unsigned Q_SWAP = 0;
    localparam int unsigned Q_XNEG = 1;
    localparam int unsigned Q_YNEG = 2;

    // 3-bit octant code {y negative, x negative, swap performed}
    typedef logic [Q_W-1:0] octant_t;

    // Build an octant code from its three flags
    function automatic octant_t make_octant(input logic yneg, input logic xneg, input logic swap);
        octant_t q;
        q         = '0;
        q[Q_YNEG] = yneg;
        q[Q_XNEG] = xneg;
        q[Q_SWAP] = swap;
        return q;
    endfunction

endpackage

// File: rtl/cordic_pre_if.sv
// Sample/result bundle of the CORDIC pre stage.
interface cordic_pre_if
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned GUARD = DEF_GUARD
);

    logic                   ena;
    logic                   vi;
    logic [WIDTH-1:0]       xi;
    logic [WIDTH-1:0]       yi;
    logic                   vo;
    logic [WIDTH+GUARD-1:0] xo;
    logic [WIDTH+GUARD-1:0] yo;
    octant_t                q;

    // Upstream producer / downstream consumer side
    modport master (
        output ena, vi, xi, yi,
        input  vo, xo, yo, q
    );

    // Pre stage side
    modport slave (
        input  ena, vi, xi, yi,
        output vo, xo, yo, q
    );

endinterface

// File: rtl/cordic_abs.sv
// Combinational two's-complement magnitude plus sign.
// The most negative input maps to 2^(WIDTH-1), which fits unsigned.
module cordic_abs
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] mag_o,
    output logic             neg_o
);

    // Sign is the MSB; negate when set
    always_comb begin
        neg_o = val_i[WIDTH-1];
        mag_o = val_i;
        if (neg_o) begin
            mag_o = WIDTH'(~val_i + WIDTH'(1));
        end
    end

endmodule

// File: rtl/cordic_pre.sv
// CORDIC vectoring input stage: folds (x, y) into the first octant
// (0 <= yo <= xo) over two enabled clock edges and emits the octant
// code the post stage needs to unfold the angle.
module cordic_pre
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned GUARD = DEF_GUARD
) (
    input  logic         clk,
    input  logic         rst,
    cordic_pre_if.slave  bus
);

    localparam int unsigned OW = WIDTH + GUARD;

    // Stage 1 combinational magnitudes
    logic [WIDTH-1:0] ax_d;
    logic [WIDTH-1:0] ay_d;
    logic             sx_d;
    logic             sy_d;

    // Stage 1 registers
    logic [WIDTH-1:0] ax_q;
    logic [WIDTH-1:0] ay_q;
    logic             sx_q;
    logic             sy_q;
    logic             v1_q;

    // Stage 2 next-state and registers
    logic             sw_c;
    logic [OW-1:0]    xo_d;
    logic [OW-1:0]    yo_d;
    octant_t          q_d;
    logic [OW-1:0]    xo_q;
    logic [OW-1:0]    yo_q;
    octant_t          q_q;
    logic             vo_q;

    cordic_abs #(.WIDTH(WIDTH)) u_abs_x (
        .val_i (bus.xi),
        .mag_o (ax_d),
        .neg_o (sx_d)
    );

    cordic_abs #(.WIDTH(WIDTH)) u_abs_y (
        .val_i (bus.yi),
        .mag_o (ay_d),
        .neg_o (sy_d)
    );

    // Stage 1: register magnitudes, signs and input valid
    always_ff @(posedge clk) begin
        if (rst) begin
            ax_q <= '0;
            ay_q <= '0;
            sx_q <= 1'b0;
            sy_q <= 1'b0;
            v1_q <= 1'b0;
        end else if (bus.ena) begin
            ax_q <= ax_d;
            ay_q <= ay_d;
            sx_q <= sx_d;
            sy_q <= sy_d;
            v1_q <= bus.vi;
        end
    end

    // Stage 2 compare/swap; equal magnitudes are left unswapped
    always_comb begin
        sw_c = (ay_q > ax_q);
        xo_d = OW'(ax_q) << GUARD;
        yo_d = OW'(ay_q) << GUARD;
        if (sw_c) begin
            xo_d = OW'(ay_q) << GUARD;
            yo_d = OW'(ax_q) << GUARD;
        end
        q_d = make_octant(sy_q, sx_q, sw_c);
    end

    // Stage 2: register folded pair, octant code and output valid
    always_ff @(posedge clk) begin
        if (rst) begin
            xo_q <= '0;
            yo_q <= '0;
            q_q  <= '0;
            vo_q <= 1'b0;
        end else if (bus.ena) begin
            xo_q <= xo_d;
            yo_q <= yo_d;
            q_q  <= q_d;
            vo_q <= v1_q;
        end
    end

    assign bus.xo = xo_q;
    assign bus.yo = yo_q;
    assign bus.q  = q_q;
    assign bus.vo = vo_q;

endmodule

// File: tb/tb_cordic_pre.sv
// Directed and random checks for cordic_pre with WIDTH=16, GUARD=2.
module tb_cordic_pre;
    import cordic_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned G  = 2;
    localparam int unsigned OW = W + G;

    typedef struct packed {
        logic          v;
        logic [OW-1:0] xo;
        logic [OW-1:0] yo;
        logic [2:0]    q;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    exp_t p1;
    exp_t p2;

    cordic_pre_if #(.WIDTH(W), .GUARD(G)) bus ();

    cordic_pre #(.WIDTH(W), .GUARD(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected folded result of one sample
    function automatic exp_t ref_out(input int x, input int y, input logic v);
        exp_t r;
        int   ax;
        int   ay;
        logic sw;
        ax   = (x < 0) ? -x : x;
        ay   = (y < 0) ? -y : y;
        sw   = (ay > ax);
        r.v  = v;
        r.xo = OW'((sw ? ay : ax) * 4);
        r.yo = OW'((sw ? ax : ay) * 4);
        r.q  = {(y < 0), (x < 0), sw};
        r.x  = W'(x);
        r.y  = W'(y);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle and advance the bench's two-deep expectation pipe
    task automatic step(input int x, input int y, input logic v, input logic e, input logic r);
        bus.xi  = W'(x);
        bus.yi  = W'(y);
        bus.vi  = v;
        bus.ena = e;
        rst     = r;
        @(posedge clk);
        #1;
        if (r) begin
            p1 = '0;
            p2 = '0;
        end else if (e) begin
            p2 = p1;
            p1 = ref_out(x, y, v);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".vo"}, 32'(bus.vo), 32'(p2.v));
        check({tag, ".xo"}, 32'(bus.xo), 32'(p2.xo));
        check({tag, ".yo"}, 32'(bus.yo), 32'(p2.yo));
        check({tag, ".q"},  32'(bus.q),  32'(p2.q));
    endtask

    task automatic check_const(input string tag, input logic v, input int xo, input int yo, input int q);
        check({tag, ".vo"}, 32'(bus.vo), 32'(v));
        check({tag, ".xo"}, 32'(bus.xo), 32'(xo));
        check({tag, ".yo"}, 32'(bus.yo), 32'(yo));
        check({tag, ".q"},  32'(bus.q),  32'(q));
    endtask

    // Unfold the DUT result and compare with the original sample
    task automatic check_unfold(input string tag);
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic [OW-1:0] ux;
        logic [OW-1:0] uy;
        int            sx;
        int            sy;
        a  = bus.xo >> G;
        b  = bus.yo >> G;
        ux = bus.q[Q_SWAP] ? b : a;
        uy = bus.q[Q_SWAP] ? a : b;
        sx = int'($signed(p2.x));
        sy = int'($signed(p2.y));
        check({tag, ".ordered"}, 32'(bus.yo <= bus.xo), 32'(1));
        check({tag, ".xlow"},    32'(bus.xo[G-1:0]), 32'(0));
        check({tag, ".ylow"},    32'(bus.yo[G-1:0]), 32'(0));
        check({tag, ".absx"},    32'(ux), 32'((sx < 0) ? -sx : sx));
        check({tag, ".absy"},    32'(uy), 32'((sy < 0) ? -sy : sy));
        check({tag, ".xneg"},    32'(bus.q[Q_XNEG]), 32'(sx < 0));
        check({tag, ".yneg"},    32'(bus.q[Q_YNEG]), 32'(sy < 0));
    endtask

    initial begin
        logic signed [W-1:0] rx;
        logic signed [W-1:0] ry;
        tests = 0;
        fails = 0;
        p1    = '0;
        p2    = '0;

        // Reset
        step(123, -45, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1);
        check_const("reset", 1'b0, 0, 0, 0);

        // Test 1: first octant, no fold
        step(1000, 300, 1'b1, 1'b1, 1'b0);
        check("t1.lat1.vo", 32'(bus.vo), 32'(0));
        step(0, 0, 1'b0, 1'b1, 1'b0);
        check_const("t1", 1'b1, 4000, 1200, 3'b000);

        // Test 2: swap, then negative x
        step(300, 1000, 1'b1, 1'b1, 1'b0);
        step(-1000, 300, 1'b1, 1'b1, 1'b0);
        check_const("t2a", 1'b1, 4000, 1200, 3'b001);
        step(0, 0, 1'b0, 1'b1, 1'b0);
        check_const("t2b", 1'b1, 4000, 1200, 3'b010);

        // Test 3: most negative pair, equal magnitudes, zero input
        step(-32768, -32768, 1'b1, 1'b1, 1'b0);
        step(500, -500, 1'b1, 1'b1, 1'b0);
        check_const("t3a", 1'b1, 131072, 131072, 3'b110);
        step(0, 0, 1'b1, 1'b1, 1'b0);
        check_const("t3b", 1'b1, 2000, 2000, 3'b100);
        step(0, 0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b1, 1'b0);
        check_const("t3zero", 1'b0, 0, 0, 3'b000);

        // Test 4: streaming with ena 1,0,0,1,1 then drain
        step(7, 9, 1'b1, 1'b1, 1'b0);
        check_model("t4.0");
        step(-20, 5, 1'b1, 1'b1, 1'b0);
        check_model("t4.1");
        step(111, -222, 1'b1, 1'b0, 1'b0);
        check_const("t4.hold1", 1'b1, 36, 28, 3'b001);
        step(333, 444, 1'b1, 1'b0, 1'b0);
        check_const("t4.hold2", 1'b1, 36, 28, 3'b001);
        step(-8, -3, 1'b1, 1'b1, 1'b0);
        check_const("t4.s2", 1'b1, 80, 20, 3'b010);
        step(2, -6, 1'b1, 1'b1, 1'b0);
        check_const("t4.s3", 1'b1, 32, 12, 3'b110);
        step(0, 0, 1'b0, 1'b1, 1'b0);
        check_const("t4.s4", 1'b1, 24, 8, 3'b101);
        step(0, 0, 1'b0, 1'b1, 1'b0);
        check_model("t4.drain");

        // Test 5: reset with two samples in flight
        step(900, 100, 1'b1, 1'b1, 1'b0);
        step(-50, 600, 1'b1, 1'b1, 1'b0);
        step(77, 77, 1'b1, 1'b0, 1'b1);
        check_const("t5.rst", 1'b0, 0, 0, 3'b000);
        step(0, 0, 1'b0, 1'b1, 1'b0);
        check("t5.flush1.vo", 32'(bus.vo), 32'(0));
        step(0, 0, 1'b0, 1'b1, 1'b0);
        check("t5.flush2.vo", 32'(bus.vo), 32'(0));
        step(40, -90, 1'b1, 1'b1, 1'b0);
        check("t5.new1.vo", 32'(bus.vo), 32'(0));
        step(0, 0, 1'b0, 1'b0, 1'b0);
        check("t5.gap.vo", 32'(bus.vo), 32'(0));
        step(0, 0, 1'b0, 1'b1, 1'b0);
        check_const("t5.new", 1'b1, 360, 160, 3'b101);

        // Test 6: random pairs with random ena
        for (int i = 0; i < 10000; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            if ((i % 97) == 0) rx = 16'sh8000;
            if ((i % 89) == 0) ry = 16'sh8000;
            if ((i % 53) == 0) ry = -rx;
            step(int'(rx), int'(ry), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 499) == 0));
            check_model("t6");
            if (p2.v) begin
                check_unfold("t6");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
